// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared types and helpers for the bus host arbiter
package bus_arb_pkg;

  localparam int unsigned MAX_HOSTS  = 8;
  localparam int unsigned HOST_IDX_W = $clog2(MAX_HOSTS);

  typedef logic [HOST_IDX_W-1:0] host_idx_t;

  typedef logic [0:0] arb_state_e;
  localparam arb_state_e ARB_IDLE = 1'b0;
  localparam arb_state_e ARB_LOCK = 1'b1;

  // Round-robin successor of idx, wrapping at nr_hosts.
  function automatic host_idx_t next_host(host_idx_t idx, int unsigned nr_hosts);
    if (32'(idx) + 32'd1 >= nr_hosts) begin
      return '0;
    end
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// rtl/arb_id_fifo.sv - in-order FIFO of host IDs for outstanding transactions
module arb_id_fifo
  import bus_arb_pkg::*;
#(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = HOST_IDX_W,
  localparam int unsigned CntW = $clog2(Depth + 1),
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] push_data_i,
  output logic [Width-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] ptr);
    if (32'(ptr) == Depth - 1) begin
      return '0;
    end
    return ptr + 1'b1;
  endfunction

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A pop frees the head slot in the same cycle, so a full FIFO may still accept a push.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/bus_host_arbiter.sv
// rtl/bus_host_arbiter.sv - round-robin arbiter sharing one bus host port between requesters
module bus_host_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned NrHosts        = 2,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned AddressWidth   = 32,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic [NrHosts-1:0]                       host_req_i,
  output logic [NrHosts-1:0]                       host_gnt_o,
  input  logic [NrHosts-1:0][AddressWidth-1:0]     host_addr_i,
  input  logic [NrHosts-1:0]                       host_we_i,
  input  logic [NrHosts-1:0][DataWidth/8-1:0]      host_be_i,
  input  logic [NrHosts-1:0][DataWidth-1:0]        host_wdata_i,
  output logic [NrHosts-1:0]                       host_rvalid_o,
  output logic [DataWidth-1:0]                     host_rdata_o,
  output logic [NrHosts-1:0]                       host_err_o,
  output logic                                     dev_req_o,
  output logic [AddressWidth-1:0]                  dev_addr_o,
  output logic                                     dev_we_o,
  output logic [DataWidth/8-1:0]                   dev_be_o,
  output logic [DataWidth-1:0]                     dev_wdata_o,
  input  logic                                     dev_gnt_i,
  input  logic                                     dev_rvalid_i,
  input  logic [DataWidth-1:0]                     dev_rdata_i,
  input  logic                                     dev_err_i,
  output logic [$clog2(MaxOutstanding+1)-1:0]      outstanding_o,
  output logic                                     rsp_unexpected_o
);

  localparam int unsigned SelW = $clog2(NrHosts);

  arb_state_e      state_q;
  host_idx_t       prio_q, sel_q, sel, win_idx, head_id;
  logic [SelW-1:0] sel_idx, head_idx;
  logic            win_valid, req_ok, room, grant, pop;
  logic            fifo_full, fifo_empty, rsp_unexpected_q;
  int unsigned     cand;

  arb_id_fifo #(
    .Depth (MaxOutstanding),
    .Width (HOST_IDX_W)
  ) u_id_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (grant),
    .pop_i       (pop),
    .push_data_i (sel),
    .head_o      (head_id),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (outstanding_o)
  );

  // First requester at or after prio_q, wrapping at NrHosts.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned i = 0; i < NrHosts; i++) begin
      cand = 32'(prio_q) + i;
      if (cand >= NrHosts) begin
        cand = cand - NrHosts;
      end
      if (!win_valid && host_req_i[SelW'(cand)]) begin
        win_valid = 1'b1;
        win_idx   = host_idx_t'(cand);
      end
    end
  end

  assign pop  = dev_rvalid_i && !fifo_empty;
  assign room = !fifo_full || pop;

  always_comb begin
    sel = win_idx;
    if (state_q == ARB_LOCK) begin
      sel = sel_q;
    end
  end

  assign sel_idx  = SelW'(sel);
  assign head_idx = SelW'(head_id);

  // Once locked the queue cannot have filled, so only the held request matters.
  always_comb begin
    req_ok = 1'b0;
    if (state_q == ARB_LOCK) begin
      req_ok = host_req_i[sel_idx];
    end else begin
      req_ok = win_valid && room;
    end
  end

  assign dev_req_o   = req_ok && !rst_i;
  assign grant       = dev_req_o && dev_gnt_i;
  assign dev_addr_o  = host_addr_i[sel_idx];
  assign dev_we_o    = host_we_i[sel_idx];
  assign dev_be_o    = host_be_i[sel_idx];
  assign dev_wdata_o = host_wdata_i[sel_idx];

  assign host_rdata_o     = dev_rdata_i;
  assign rsp_unexpected_o = rsp_unexpected_q;

  always_comb begin
    host_gnt_o    = '0;
    host_rvalid_o = '0;
    host_err_o    = '0;
    if (grant) begin
      host_gnt_o[sel_idx] = 1'b1;
    end
    if (pop) begin
      host_rvalid_o[head_idx] = 1'b1;
      host_err_o[head_idx]    = dev_err_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q          <= ARB_IDLE;
      prio_q           <= '0;
      sel_q            <= '0;
      rsp_unexpected_q <= 1'b0;
    end else begin
      if (dev_rvalid_i && fifo_empty) begin
        rsp_unexpected_q <= 1'b1;
      end
      if (grant) begin
        prio_q  <= next_host(sel, NrHosts);
        state_q <= ARB_IDLE;
      end else if (state_q == ARB_IDLE && req_ok) begin
        sel_q   <= sel;
        state_q <= ARB_LOCK;
      end else if (state_q == ARB_LOCK && !req_ok) begin
        state_q <= ARB_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_bus_host_arbiter.sv
// tb/tb_bus_host_arbiter.sv - directed and random checks of bus_host_arbiter against a queue model
module tb_bus_host_arbiter;

  localparam int N  = 2;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MO = 2;
  localparam int CW = $clog2(MO + 1);
  localparam int SW = $clog2(N);

  logic                    clk = 1'b0;
  logic                    rst;
  logic [N-1:0]            host_req, host_gnt, host_we, host_rvalid, host_err;
  logic [N-1:0][AW-1:0]    host_addr;
  logic [N-1:0][DW/8-1:0]  host_be;
  logic [N-1:0][DW-1:0]    host_wdata;
  logic [DW-1:0]           host_rdata;
  logic                    dev_req, dev_we, dev_gnt, dev_rvalid, dev_err;
  logic [AW-1:0]           dev_addr;
  logic [DW/8-1:0]         dev_be;
  logic [DW-1:0]           dev_wdata, dev_rdata;
  logic [CW-1:0]           outstanding;
  logic                    rsp_unexpected;

  int checks = 0;
  int fails  = 0;

  // Reference model: owner queue, round-robin pointer, host held while waiting for gnt.
  int          q[$];
  int          m_prio, m_lock, e_cand;
  bit          m_unexp, e_req;
  logic [N-1:0] e_gnt, e_rvalid, e_err;

  bus_host_arbiter #(
    .NrHosts(N), .DataWidth(DW), .AddressWidth(AW), .MaxOutstanding(MO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .host_req_i(host_req), .host_gnt_o(host_gnt), .host_addr_i(host_addr),
    .host_we_i(host_we), .host_be_i(host_be), .host_wdata_i(host_wdata),
    .host_rvalid_o(host_rvalid), .host_rdata_o(host_rdata), .host_err_o(host_err),
    .dev_req_o(dev_req), .dev_addr_o(dev_addr), .dev_we_o(dev_we), .dev_be_o(dev_be),
    .dev_wdata_o(dev_wdata), .dev_gnt_i(dev_gnt), .dev_rvalid_i(dev_rvalid),
    .dev_rdata_i(dev_rdata), .dev_err_i(dev_err),
    .outstanding_o(outstanding), .rsp_unexpected_o(rsp_unexpected)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    q.delete();
    m_prio  = 0;
    m_lock  = -1;
    m_unexp = 1'b0;
  endtask

  task automatic eval();
    bit pop_ok, room;
    logic [SW-1:0] ci, hi;
    @(negedge clk);
    e_cand = -1;
    pop_ok = dev_rvalid && (q.size() > 0);
    room   = (q.size() < MO) || pop_ok;
    if (m_lock >= 0) begin
      if (host_req[SW'(m_lock)]) e_cand = m_lock;
    end else if (room) begin
      for (int i = 0; i < N; i++) begin
        int h;
        h = (m_prio + i) % N;
        if (e_cand < 0 && host_req[SW'(h)]) e_cand = h;
      end
    end
    e_req    = (e_cand >= 0);
    ci       = SW'(e_cand);
    e_gnt    = '0;
    e_rvalid = '0;
    e_err    = '0;
    if (e_req && dev_gnt) e_gnt[ci] = 1'b1;
    if (pop_ok) begin
      hi = SW'(q[0]);
      e_rvalid[hi] = 1'b1;
      e_err[hi]    = dev_err;
    end
    check("dev_req", dev_req, e_req);
    if (e_req) begin
      check("dev_addr", dev_addr, host_addr[ci]);
      check("dev_we", dev_we, host_we[ci]);
      check("dev_be", dev_be, host_be[ci]);
      check("dev_wdata", dev_wdata, host_wdata[ci]);
    end
    check("host_gnt", host_gnt, e_gnt);
    check("host_rvalid", host_rvalid, e_rvalid);
    check("host_err", host_err & host_rvalid, e_err);
    check("host_rdata", host_rdata, dev_rdata);
    check("outstanding", outstanding, q.size());
    check("rsp_unexpected", rsp_unexpected, m_unexp);
  endtask

  task automatic tick();
    if (dev_rvalid && q.size() == 0) m_unexp = 1'b1;
    if (e_rvalid != '0) void'(q.pop_front());
    if (e_gnt != '0) begin
      q.push_back(e_cand);
      m_prio = (e_cand + 1) % N;
      m_lock = -1;
    end else if (e_req) begin
      m_lock = e_cand;
    end else begin
      m_lock = -1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    host_req = '0; dev_gnt = 1'b0; dev_rvalid = 1'b0; dev_err = 1'b0;
    rst = 1'b1;
    m_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    host_req = '0; host_addr = '0; host_we = '0; host_be = '0; host_wdata = '0;
    dev_gnt = 1'b0; dev_rvalid = 1'b0; dev_rdata = '0; dev_err = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    host_req = 2'b11;
    dev_gnt  = 1'b1;
    #1;
    check("rst_dev_req", dev_req, 1'b0);
    check("rst_host_gnt", host_gnt, 2'b00);
    check("rst_host_rvalid", host_rvalid, 2'b00);
    check("rst_outstanding", outstanding, 0);
    check("rst_unexpected", rsp_unexpected, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Continuous requests from both hosts: alternating grants, per-host read data.
    host_addr[0] = 32'h0000_0100; host_addr[1] = 32'h0000_0200;
    host_we = 2'b10; host_be[0] = 4'hF; host_be[1] = 4'h3;
    host_wdata[0] = 32'h1111_1111; host_wdata[1] = 32'h2222_2222;
    host_req = 2'b11;
    dev_gnt  = 1'b1;
    for (int k = 0; k < 6; k++) begin
      dev_rvalid = (k > 0);
      dev_rdata  = (k == 0) ? 32'h0 : ((k % 2 == 1) ? 32'hA5A5_A5A5 : 32'h5A5A_5A5A);
      eval();
      check("rr_gnt", host_gnt, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k > 0) check("rr_rvalid", host_rvalid, (k % 2 == 1) ? 2'b01 : 2'b10);
      tick();
    end
    host_req = '0; dev_rvalid = 1'b1; dev_rdata = 32'h5A5A_5A5A;
    eval();
    check("drain_rvalid_h1", host_rvalid, 2'b10);
    check("drain_rdata_h1", host_rdata, 32'h5A5A_5A5A);
    tick();
    dev_rvalid = 1'b0;

    // Stalled grant: H0 stays locked downstream while H1 also requests.
    host_addr[0] = 32'h0000_1000; host_addr[1] = 32'h0000_2000;
    host_req = 2'b11; dev_gnt = 1'b0;
    repeat (3) begin
      eval();
      check("lock_addr", dev_addr, 32'h0000_1000);
      check("lock_nogrant", host_gnt, 2'b00);
      tick();
    end
    dev_gnt = 1'b1;
    eval();
    check("lock_grant_h0", host_gnt, 2'b01);
    tick();
    eval();
    check("next_grant_h1", host_gnt, 2'b10);
    tick();

    // Queue full, then a response and a new grant in the same cycle.
    eval();
    check("full_outstanding", outstanding, 2);
    check("full_no_req", dev_req, 1'b0);
    tick();
    dev_rvalid = 1'b1; dev_rdata = 32'hA5A5_A5A5; dev_err = 1'b0;
    eval();
    check("swap_grant", host_gnt, 2'b01);
    check("swap_rvalid", host_rvalid, 2'b01);
    tick();
    host_req = '0; dev_rvalid = 1'b0;
    eval();
    check("swap_outstanding", outstanding, 2);
    tick();

    // Error on the first of the two queued responses (owners H1 then H0).
    dev_rvalid = 1'b1; dev_err = 1'b1;
    eval();
    check("err_rvalid_h1", host_rvalid, 2'b10);
    check("err_flag_h1", host_err, 2'b10);
    tick();
    dev_err = 1'b0;
    eval();
    check("ok_rvalid_h0", host_rvalid, 2'b01);
    check("ok_flag_h0", host_err, 2'b00);
    tick();
    dev_rvalid = 1'b0;

    // Response with nothing outstanding is dropped and flagged stickily.
    do_reset();
    dev_rvalid = 1'b1;
    eval();
    check("unexp_no_rvalid", host_rvalid, 2'b00);
    tick();
    dev_rvalid = 1'b0;
    repeat (3) begin
      eval();
      check("unexp_sticky", rsp_unexpected, 1'b1);
      tick();
    end

    // Reset while one transaction is outstanding and H1 is locked.
    do_reset();
    host_req = 2'b01; dev_gnt = 1'b1;
    eval();
    tick();
    host_req = 2'b10; dev_gnt = 1'b0;
    eval();
    check("prelock_outstanding", outstanding, 1);
    tick();
    rst = 1'b1; dev_gnt = 1'b1;
    #1;
    check("midrst_dev_req", dev_req, 1'b0);
    check("midrst_outstanding", outstanding, 0);
    check("midrst_gnt", host_gnt, 2'b00);
    m_reset();
    @(posedge clk);
    #1;
    rst = 1'b0; host_req = 2'b11;
    eval();
    check("postrst_prio_h0", host_gnt, 2'b01);
    tick();

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      host_req   = N'($urandom);
      host_we    = N'($urandom);
      for (int h = 0; h < N; h++) begin
        host_addr[h]  = $urandom;
        host_be[h]    = (DW/8)'($urandom);
        host_wdata[h] = $urandom;
      end
      dev_gnt    = ($urandom_range(0, 2) != 0);
      dev_rvalid = ($urandom_range(0, 2) == 0);
      dev_err    = 1'($urandom);
      dev_rdata  = $urandom;
      eval();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
